// File: rtl/inst_queue_pkg.sv
// Shared widths and entry type for the fetch-to-decode instruction queue.
// Holds InstWidth, AddrWidth, IQ_ADDR_BITS/IQ_SIZE, True/False and iq_entry_t.
package inst_queue_pkg;

    localparam int InstWidth    = 32;
    localparam int AddrWidth    = 32;
    localparam int IQ_ADDR_BITS = 4;
    localparam int IQ_SIZE      = 2 ** IQ_ADDR_BITS;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    typedef struct packed {
        logic [InstWidth-1:0] inst;
        logic [AddrWidth-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// master: fetcher+decoder side; slave: the queue itself.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic                 IF_inst_valid;
    logic [InstWidth-1:0] IF_inst;
    logic [AddrWidth-1:0] IF_pc;
    logic                 IQ_is_full;
    logic                 DC_enable;
    logic                 IQ_inst_valid;
    logic [InstWidth-1:0] IQ_inst;
    logic [AddrWidth-1:0] IQ_pc;

    modport master (
        output IF_inst_valid, IF_inst, IF_pc, DC_enable,
        input  IQ_is_full, IQ_inst_valid, IQ_inst, IQ_pc
    );

    modport slave (
        input  IF_inst_valid, IF_inst, IF_pc, DC_enable,
        output IQ_is_full, IQ_inst_valid, IQ_inst, IQ_pc
    );

endinterface

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetcher and decoder, show-ahead head.
// Ports: clk, rst (sync, high), rdy (global stall), ROB_clear (flush), bus (slave).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int ADDR_BITS = IQ_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        ROB_clear,
    inst_queue_if.slave bus
);

    localparam int SIZE = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FullCount = (ADDR_BITS + 1)'(SIZE);

    logic [InstWidth-1:0] inst_mem [SIZE];
    logic [AddrWidth-1:0] pc_mem   [SIZE];

    logic [ADDR_BITS-1:0] head;
    logic [ADDR_BITS-1:0] tail;
    logic [ADDR_BITS:0]   count;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic advance;

    assign empty = (count == '0);
    assign full  = (count == FullCount);

    // A pop frees a slot in the same edge, so a full queue still
    // accepts a push when the decoder consumes.
    assign pop  = bus.DC_enable && !empty;
    assign push = bus.IF_inst_valid && (!full || pop);

    // Push/pop only take effect on a live, non-flushing cycle.
    assign advance = rdy && !ROB_clear && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy && ROB_clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (advance && push) begin
            inst_mem[tail] <= bus.IF_inst;
            pc_mem[tail]   <= bus.IF_pc;
        end
    end

    assign bus.IQ_is_full    = full;
    assign bus.IQ_inst_valid = !empty;
    assign bus.IQ_inst       = empty ? '0 : inst_mem[head];
    assign bus.IQ_pc         = empty ? '0 : pc_mem[head];

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue against a queue-based model.
// Ports: none; drives clk/rst/rdy/ROB_clear and the bus master side.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic ROB_clear;

    inst_queue_if bus ();

    inst_queue dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .ROB_clear (ROB_clear),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    iq_entry_t mq[$];
    int n_chk  = 0;
    int n_fail = 0;
    int n_viol = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] inst,
                         input logic [31:0] pc, input logic de);
        bus.IF_inst_valid = iv;
        bus.IF_inst       = inst;
        bus.IF_pc         = pc;
        bus.DC_enable     = de;
    endtask

    // Apply the queue rules to the inputs seen at this edge.
    task automatic model_edge();
        bit do_pop;
        bit do_push;
        iq_entry_t e;
        if (rst || (rdy && ROB_clear)) begin
            mq.delete();
        end else if (rdy) begin
            do_pop  = bus.DC_enable && mq.size() > 0;
            do_push = bus.IF_inst_valid && (mq.size() < IQ_SIZE || do_pop);
            if (bus.IF_inst_valid && !do_push) begin
                n_viol++;
                $display("note: push while full dropped (pc %0h)", bus.IF_pc);
            end
            if (do_pop) begin
                void'(mq.pop_front());
            end
            if (do_push) begin
                e.inst = bus.IF_inst;
                e.pc   = bus.IF_pc;
                mq.push_back(e);
            end
        end
    endtask

    task automatic compare();
        bit v;
        v = mq.size() > 0;
        chk("valid", 64'(bus.IQ_inst_valid), 64'(v));
        chk("inst", 64'(bus.IQ_inst), v ? 64'(mq[0].inst) : 64'd0);
        chk("pc", 64'(bus.IQ_pc), v ? 64'(mq[0].pc) : 64'd0);
        chk("full", 64'(bus.IQ_is_full), 64'(mq.size() == IQ_SIZE));
        chk("count", 64'(dut.count), 64'(mq.size()));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        ROB_clear = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int viol0;
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic [31:0] t1 [3];
        t1[0] = 32'h0000_0013;
        t1[1] = 32'h0010_0093;
        t1[2] = 32'h0020_0113;

        // Reset state and first three pushes.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, t1[i], 32'(i * 4), 1'b0);
            step();
            if (i == 0) begin
                chk("first_inst", 64'(bus.IQ_inst), 64'h13);
                chk("first_pc", 64'(bus.IQ_pc), 64'h0);
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        step();
        chk("count3", 64'(dut.count), 64'd3);

        // Fill to 16, overflow attempt, drain in order.
        do_reset();
        for (int i = 0; i < IQ_SIZE; i++) begin
            drive(1'b1, $urandom, 32'(i * 4), 1'b0);
            step();
            chk("fill_full", 64'(bus.IQ_is_full), 64'(i == IQ_SIZE - 1));
        end
        viol0 = n_viol;
        drive(1'b1, 32'hdead_beef, 32'h40, 1'b0);
        step();
        chk("drop_flag", 64'(n_viol - viol0), 64'd1);
        for (int i = 0; i < IQ_SIZE; i++) begin
            chk("drain_pc", 64'(bus.IQ_pc), 64'(i * 4));
            drive(1'b0, '0, '0, 1'b1);
            step();
        end
        chk("drained", 64'(bus.IQ_inst_valid), 64'd0);

        // Full queue with simultaneous push/pop for 20 cycles.
        for (int i = 0; i < IQ_SIZE; i++) begin
            drive(1'b1, $urandom, 32'h1000 + 32'(i * 4), 1'b0);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            chk("stream_pc", 64'(bus.IQ_pc), 64'(32'h1000 + 32'(i * 4)));
            drive(1'b1, $urandom, 32'h1000 + 32'((i + IQ_SIZE) * 4), 1'b1);
            step();
            chk("stream_full", 64'(bus.IQ_is_full), 64'd1);
        end

        // Flush together with push and pop.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, 32'(i * 4), 1'b0);
            step();
        end
        ROB_clear = 1'b1;
        drive(1'b1, 32'h1234_5678, 32'h14, 1'b1);
        step();
        ROB_clear = 1'b0;
        chk("flush_valid", 64'(bus.IQ_inst_valid), 64'd0);
        chk("flush_count", 64'(dut.count), 64'd0);
        drive(1'b1, 32'h0000_0013, 32'h100, 1'b0);
        step();
        chk("post_flush_pc", 64'(bus.IQ_pc), 64'h100);

        // Stall with push and pop requested.
        drive(1'b1, $urandom, 32'h104, 1'b0);
        step();
        held_pc   = bus.IQ_pc;
        held_inst = bus.IQ_inst;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 32'h200 + 32'(i * 4), 1'b1);
            step();
            chk("stall_pc", 64'(bus.IQ_pc), 64'(held_pc));
            chk("stall_inst", 64'(bus.IQ_inst), 64'(held_inst));
            chk("stall_count", 64'(dut.count), 64'd2);
        end
        rdy = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        step();
        chk("resume_pc", 64'(bus.IQ_pc), 64'h104);

        // Pop on empty with simultaneous push.
        do_reset();
        drive(1'b1, 32'h0000_0073, 32'h300, 1'b1);
        step();
        chk("empty_pop_count", 64'(dut.count), 64'd1);
        chk("empty_pop_valid", 64'(bus.IQ_inst_valid), 64'd1);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rdy       = ($urandom_range(0, 99) < 90);
            ROB_clear = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 60, $urandom, $urandom,
                  $urandom_range(0, 99) < 45);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Circular FIFO of fetched instructions between the instruction fetcher and the decoder. Accepts one {inst, pc} pair per cycle from the fetcher. Presents the oldest entry to the decoder through a show-ahead read port so the combinational decoder can decode it in the same cycle. Flushes completely on a reorder-buffer clear (branch mispredict / jalr redirect).

## Interface
- `IQ_ADDR_BITS`, default 4: log2 of depth; depth `IQ_SIZE = 2**IQ_ADDR_BITS` (16 entries).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global ready; low freezes all state.
- `ROB_clear`  in  1  flush request from the reorder buffer.
- `IF_inst_valid`  in  1  fetcher pushes `{IF_inst, IF_pc}` this cycle.
- `IF_inst`  in  32  instruction word.
- `IF_pc`  in  32  instruction address.
- `IQ_is_full`  out  1  queue holds `IQ_SIZE` entries.
- `DC_enable`  in  1  decoder consumes the head entry this cycle.
- `IQ_inst_valid`  out  1  head entry present.
- `IQ_inst`  out  32  head instruction.
- `IQ_pc`  out  32  head pc.

## Operation
- State:
  - `inst_mem[IQ_SIZE]`, `pc_mem[IQ_SIZE]`.
  - `head`, `tail`: `IQ_ADDR_BITS` wide each; wrap naturally modulo `IQ_SIZE`.
  - `count`: `IQ_ADDR_BITS+1` wide, range 0..`IQ_SIZE`.
- Priority at each posedge:
  1. `rst`, regardless of `rdy`: `head`, `tail`, `count` ← 0. Memory contents are don't-care.
  2. `ROB_clear` with `rdy`: same as reset. Any push or pop in that cycle is discarded.
  3. `rdy` low: hold everything; ignore push and pop.
  4. Otherwise, evaluate push and pop:
     - pop = `DC_enable && count != 0`.
     - push = `IF_inst_valid && (count != IQ_SIZE || pop)`.
- Push: write the entry at `tail`; `tail` ← `tail+1`.
- Pop: `head` ← `head+1`.
- Count update: `count` +1 for push only, −1 for pop only, unchanged for both or neither.
- Push while full with no pop: the entry is dropped and state is unchanged. This is a fetcher protocol violation; the bench must flag it.
- `DC_enable` while empty: ignored.
- Read port (combinational from registered state):
  - `IQ_inst_valid` = `count != 0`.
  - `IQ_inst` / `IQ_pc` = `mem[head]` when valid, else 0.
- `IQ_is_full` = `count == IQ_SIZE`, combinational from registered `count`. It does not depend on the same-cycle `DC_enable`.

## Timing
- Reset values: `IQ_inst_valid` 0, `IQ_inst` 0, `IQ_pc` 0, `IQ_is_full` 0.
- Push-to-visible latency: 1 cycle. An entry pushed at edge N appears at the head output after edge N when the queue was empty.
- No bypass from `IF_*` to `IQ_*` in the same cycle.
- Pop: the decoder samples head outputs during cycle N and asserts `DC_enable`. The next entry appears after edge N.
- Sustained throughput: 1 push plus 1 pop per cycle, including at `count == IQ_SIZE`. A simultaneous push and pop when full keeps `count` at `IQ_SIZE`.
- Flush latency: after a `ROB_clear` edge, `IQ_inst_valid` is 0 the next cycle. The first post-flush push is visible one cycle after it is accepted.
- Wrap-around: `head`/`tail` roll over from `IQ_SIZE-1` to 0 with no bubble.
- `rdy` low mid-stream: outputs stay stable (same head entry), and `IQ_is_full` holds.

## Structure
- Shared defines, in the existing defines include: `InstWidth` (32), `AddrWidth` (32), `IQ_ADDR_BITS`/`IQ_SIZE`, and `True`/`False`.
- Single module with no sub-modules. Storage is flat register arrays; no SRAM macro.

## Test plan
- Reset, then push pc 0x0, 0x4, 0x8 (inst 0x00000013, 0x00100093, 0x00200113) with no pops → `count` 3; head shows 0x00000013 / pc 0x0 one cycle after the first push.
- Fill 16 entries with no pop → `IQ_is_full`=1 exactly after the 16th push. A 17th push without pop is dropped; popping all 16 returns pc 0x0..0x3C in order.
- Full queue, push and pop in the same cycle, held for 20 cycles → `IQ_is_full` stays 1, order preserved, `head`/`tail` wrap correctly.
- 5 entries queued; assert `ROB_clear` together with a push and a pop → next cycle `IQ_inst_valid`=0 and `count`=0. A subsequent push of pc 0x100 appears one cycle later.
- Drop `rdy` for 3 cycles while `IF_inst_valid` and `DC_enable` are asserted → no state change, head output constant; operation resumes on `rdy`=1.
- Empty queue with `DC_enable`=1 and a simultaneous push → pop ignored, `count` becomes 1, `IQ_inst_valid`=1 next cycle.
